// File: rtl/lpc_step_up_pkg.sv
// Shared definitions for the LPC step-up engine: FSM encoding, float constants
// and the default pipeline depths of the floating-point cores.
package lpc_step_up_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam logic [31:0] FP_ZERO          = 32'h0000_0000;
  localparam int          DEF_MULT_LATENCY = 5;
  localparam int          DEF_ADD_LATENCY  = 7;
  localparam int          CNT_W            = 8;
endpackage

// File: rtl/fp_add_sub.sv
// Single-precision adder/subtractor, round-to-nearest-even, denormals flushed;
// result emerges LATENCY enabled cycles after the operands.
module fp_add_sub #(
  parameter int LATENCY = 7
) (
  input  logic        clk,
  input  logic        en,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic [31:0] bb, x, y, res_c;
  logic [23:0] mx, my, man_r;
  logic [51:0] xa, xb, s;
  logic [50:0] n;
  logic        eff_sub, guard, sticky;
  logic [31:0] pipe [LATENCY];
  int          d, p, e;

  always_comb begin
    bb = {b[31] ^ sub, b[30:0]};
    if (bb[30:0] > a[30:0]) begin
      x = bb;
      y = a;
    end else begin
      x = a;
      y = bb;
    end
    eff_sub = x[31] ^ y[31];
    d  = int'(x[30:23]) - int'(y[30:23]);
    mx = {1'b1, x[22:0]};
    my = (y[30:23] == 8'd0) ? 24'd0 : {1'b1, y[22:0]};
    // 27 guard bits keep the aligned small operand exact; beyond that it is below half an ulp
    xa = {1'b0, mx, 27'd0};
    xb = (d > 26) ? 52'd0 : ({1'b0, my, 27'd0} >> d);
    s  = eff_sub ? xa - xb : xa + xb;
    p  = 0;
    for (int i = 0; i < 52; i++) if (s[i]) p = i;
    n      = 51'(s << (51 - p));
    guard  = n[27];
    sticky = |n[26:0];
    man_r  = {1'b0, n[50:28]} + 24'(guard & (sticky | n[28]));
    e      = int'(x[30:23]) + p - 50 + int'(man_r[23]);
    if (x[30:23] == 8'd0)             res_c = {x[31] & y[31], 31'd0};
    else if (s == 52'd0 || e <= 0)    res_c = 32'd0;
    else if (e >= 255)                res_c = {x[31], 8'hFF, 23'd0};
    else                              res_c = {x[31], e[7:0], man_r[22:0]};
  end

  always_ff @(posedge clk) begin
    if (en) begin
      pipe[0] <= res_c;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign result = pipe[LATENCY-1];
endmodule

// File: rtl/fp_mult.sv
// Single-precision multiplier, round-to-nearest-even, denormals flushed to zero;
// result emerges LATENCY enabled cycles after the operands.
module fp_mult #(
  parameter int LATENCY = 5
) (
  input  logic        clk,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic [47:0] prod;
  logic [22:0] man;
  logic [23:0] man_r;
  logic        sign, guard, sticky;
  logic [31:0] res_c;
  logic [31:0] pipe [LATENCY];
  int          e;

  always_comb begin
    sign = a[31] ^ b[31];
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e    = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) begin
      man    = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      e      = e + 1;
    end else begin
      man    = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    man_r = {1'b0, man} + 24'(guard & (sticky | man[0]));
    e     = e + int'(man_r[23]);
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 0) res_c = {sign, 31'd0};
    else if (e >= 255)                                   res_c = {sign, 8'hFF, 23'd0};
    else                                                 res_c = {sign, e[7:0], man_r[22:0]};
  end

  always_ff @(posedge clk) begin
    if (en) begin
      pipe[0] <= res_c;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign result = pipe[LATENCY-1];
endmodule

// File: rtl/lpc_delay_line.sv
// Enable-gated delay line carrying a valid flag and payload; valids can be
// flushed so an aborted operation leaves nothing behind in the pipe.
module lpc_delay_line #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             vld,
  input  logic [WIDTH-1:0] data,
  output logic             vld_q,
  output logic [WIDTH-1:0] data_q
);
  logic [DEPTH-1:0] vld_sr;
  logic [WIDTH-1:0] data_sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
    end else if (flush) begin
      vld_sr <= '0;
    end else if (en) begin
      vld_sr[0] <= vld;
      for (int i = 1; i < DEPTH; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      data_sr[0] <= data;
      for (int i = 1; i < DEPTH; i++) data_sr[i] <= data_sr[i-1];
    end
  end

  assign vld_q  = vld_sr[DEPTH-1];
  assign data_q = data_sr[DEPTH-1];
endmodule

// File: rtl/lpc_step_up.sv
// LPC step-up recursion engine: a_i += k*a_(m+1-i), a_(m+1) = k, m++.
// Optional build macro LPC_STEP_UP_KNEG_EN negates k at capture.
//   state     | meaning
//   ST_IDLE   | waiting for start/clear, arithmetic disabled
//   ST_ISSUE  | feeding one index per cycle into the multiplier
//   ST_DRAIN  | letting the multiply/add pipelines empty into shadow
//   ST_COMMIT | copy shadow to committed array, append k, bump order
module lpc_step_up
  import lpc_step_up_pkg::*;
#(
  parameter int MAX_ORDER    = 12,
  parameter int MULT_LATENCY = DEF_MULT_LATENCY,
  parameter int ADD_LATENCY  = DEF_ADD_LATENCY
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iClear,
  input  logic        iStart,
  input  logic [31:0] iK,
  input  logic [4:0]  iReadIdx,
  output logic [31:0] oCoef,
  output logic [4:0]  oOrder,
  output logic        oBusy,
  output logic        oDone,
  output logic        oOverflow
);
  localparam logic [CNT_W-1:0] DRAIN_CYCLES = CNT_W'(MULT_LATENCY + ADD_LATENCY);
  localparam logic [4:0]       MAX_M        = 5'(MAX_ORDER);

  state_t           state, state_nxt;
  logic [31:0]      coef   [32];
  logic [31:0]      shadow [32];
  logic [4:0]       order, idx, idx_mul, idx_add;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      k, k_in, op_near, op_far, near_dly, prod, sum;
  logic             ce, flush, accept, reject, vld_mul, vld_add;

`ifdef LPC_STEP_UP_KNEG_EN
  assign k_in = {~iK[31], iK[30:0]};
`else
  assign k_in = iK;
`endif

  assign accept  = (state == ST_IDLE) && iStart && !iClear && (order != MAX_M);
  assign reject  = (state == ST_IDLE) && iStart && !iClear && (order == MAX_M);
  assign ce      = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign flush   = (state == ST_IDLE);
  assign op_near = coef[idx];
  assign op_far  = coef[order - idx + 5'd1];
  assign oBusy   = (state != ST_IDLE);
  assign oOrder  = order;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = (order == 5'd0) ? ST_COMMIT : ST_ISSUE;
      ST_ISSUE:  if (iClear) state_nxt = ST_IDLE;
                 else if (cnt == CNT_W'(1)) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (iClear) state_nxt = ST_IDLE;
                 else if (cnt == CNT_W'(1)) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      order     <= '0;
      idx       <= '0;
      cnt       <= '0;
      k         <= FP_ZERO;
      oCoef     <= FP_ZERO;
      oDone     <= 1'b0;
      oOverflow <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        coef[i]   <= FP_ZERO;
        shadow[i] <= FP_ZERO;
      end
    end else begin
      oDone     <= (state == ST_COMMIT) && !iClear;
      oOverflow <= reject;
      oCoef     <= (iReadIdx != 5'd0 && iReadIdx <= order) ? coef[iReadIdx] : FP_ZERO;
      case (state)
        ST_IDLE: begin
          if (iClear) begin
            order <= '0;
            for (int i = 0; i < 32; i++) begin
              coef[i]   <= FP_ZERO;
              shadow[i] <= FP_ZERO;
            end
          end else if (accept) begin
            k   <= k_in;
            idx <= 5'd1;
            cnt <= CNT_W'(order);
          end
        end
        ST_ISSUE: begin
          idx <= idx + 5'd1;
          cnt <= (cnt == CNT_W'(1)) ? DRAIN_CYCLES : cnt - CNT_W'(1);
        end
        ST_DRAIN: cnt <= cnt - CNT_W'(1);
        ST_COMMIT: begin
          if (!iClear) begin
            for (int i = 1; i <= MAX_ORDER; i++) begin
              if (5'(i) <= order) coef[i] <= shadow[i];
            end
            coef[order + 5'd1] <= k;
            order              <= order + 5'd1;
          end
        end
        default: ;
      endcase
      if (ce && vld_add) shadow[idx_add] <= sum;
    end
  end

  fp_mult #(.LATENCY(MULT_LATENCY)) u_mult (
    .clk(iClock), .en(ce), .a(k), .b(op_far), .result(prod)
  );

  // a_i rides alongside the product so both reach the adder together
  lpc_delay_line #(.DEPTH(MULT_LATENCY), .WIDTH(37)) u_dly_mul (
    .clk(iClock), .rst(iReset), .en(ce), .flush(flush),
    .vld(state == ST_ISSUE), .data({idx, op_near}),
    .vld_q(vld_mul), .data_q({idx_mul, near_dly})
  );

  fp_add_sub #(.LATENCY(ADD_LATENCY)) u_add (
    .clk(iClock), .en(ce), .sub(1'b0), .a(near_dly), .b(prod), .result(sum)
  );

  lpc_delay_line #(.DEPTH(ADD_LATENCY), .WIDTH(5)) u_dly_add (
    .clk(iClock), .rst(iReset), .en(ce), .flush(flush),
    .vld(vld_mul), .data(idx_mul),
    .vld_q(vld_add), .data_q(idx_add)
  );
endmodule

// File: tb/tb_lpc_step_up.sv
// Self-checking bench for lpc_step_up against a real-valued step-up model.
module tb_lpc_step_up;
  localparam int MAXO = 12;
  localparam int ML   = 5;
  localparam int AL   = 7;

  logic        clk = 1'b0;
  logic        rst, clr, start;
  logic [31:0] k_drv;
  logic [4:0]  ridx;
  logic [31:0] coef;
  logic [4:0]  order;
  logic        busy, done, ovf;

  int  n_checks = 0;
  int  n_fail   = 0;
  real mdl [0:MAXO+1];
  int  mdl_m;
  real kset [6] = '{0.5, -0.5, 0.25, -0.25, 0.75, -0.75};

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] exp;
  } rd_vec_t;
  rd_vec_t tbl [6];

  always #5 clk = ~clk;

  lpc_step_up #(.MAX_ORDER(MAXO), .MULT_LATENCY(ML), .ADD_LATENCY(AL)) dut (
    .iClock(clk), .iReset(rst), .iClear(clr), .iStart(start), .iK(k_drv),
    .iReadIdx(ridx), .oCoef(coef), .oOrder(order), .oBusy(busy),
    .oDone(done), .oOverflow(ovf)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  // exact reals only: repack the double into single-precision bits
  function automatic logic [31:0] fbits(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i <= MAXO + 1; i++) mdl[i] = 0.0;
    mdl_m = 0;
  endtask

  task automatic model_step(input real kv);
    real kk;
    real nw [0:MAXO+1];
    kk = kv;
`ifdef LPC_STEP_UP_KNEG_EN
    kk = -kv;
`endif
    nw = mdl;
    for (int i = 1; i <= mdl_m; i++) nw[i] = mdl[i] + kk * mdl[mdl_m + 1 - i];
    nw[mdl_m + 1] = kk;
    mdl = nw;
    mdl_m++;
  endtask

  task automatic read_coef(input int i, output logic [31:0] v);
    @(negedge clk);
    ridx = 5'(i);
    @(posedge clk);
    @(negedge clk);
    v = coef;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    chk($sformatf("%s order", tag), 32'(order), 32'(mdl_m));
    for (int i = 0; i <= MAXO + 1; i++) begin
      read_coef(i, v);
      chk($sformatf("%s a%0d", tag, i), v, (i == 0 || i > mdl_m) ? 32'd0 : fbits(mdl[i]));
    end
  endtask

  task automatic count_done(input int cycles, input string tag);
    int nd;
    nd = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk($sformatf("%s no done", tag), 32'(nd), 32'd0);
  endtask

  task automatic do_step(input real kv, input bit poke, input string tag);
    int lat;
    int m0;
    m0 = mdl_m;
    @(negedge clk);
    k_drv = fbits(kv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      if (poke && c == 2) begin
        start = 1'b1;
        k_drv = fbits(1.0);
      end
      if (c == 3) start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
    model_step(kv);
    chk($sformatf("%s latency m=%0d", tag, m0), 32'(lat), 32'((m0 == 0) ? 1 : m0 + ML + AL + 1));
    chk($sformatf("%s idle at done", tag), 32'(busy), 32'd0);
    @(negedge clk);
    chk($sformatf("%s done width", tag), 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1; clr = 1'b0; start = 1'b0; k_drv = 32'd0; ridx = 5'd0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset oCoef", coef, 32'd0);
    chk("reset oOrder", 32'(order), 32'd0);
    chk("reset oBusy", 32'(busy), 32'd0);
    chk("reset oDone", 32'(done), 32'd0);
    chk("reset oOverflow", 32'(ovf), 32'd0);
    rst = 1'b0;

    do_step(0.5, 1'b0, "s1");
    read_coef(1, v);
    chk("s1 a1", v, 32'h3F000000);
    chk("s1 order", 32'(order), 32'd1);
    do_step(0.25, 1'b0, "s2");
    read_coef(1, v);
    chk("s2 a1", v, 32'h3F200000);
    read_coef(2, v);
    chk("s2 a2", v, 32'h3E800000);
    do_step(-0.5, 1'b1, "s3");

    tbl[0] = '{5'd0,  32'h00000000};
    tbl[1] = '{5'd1,  32'h3F000000};
    tbl[2] = '{5'd2,  32'hBD800000};
    tbl[3] = '{5'd3,  32'hBF000000};
    tbl[4] = '{5'd4,  32'h00000000};
    tbl[5] = '{5'd31, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      read_coef(int'(tbl[i].idx), v);
      chk($sformatf("s3 table idx%0d", tbl[i].idx), v, tbl[i].exp);
    end

    while (mdl_m < MAXO) do_step(($urandom_range(0, 1) != 0) ? 0.5 : -0.5, mdl_m[0], "fill");
    check_all("full");

    @(negedge clk);
    k_drv = fbits(1.0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("overflow pulse", 32'(ovf), 32'd1);
    chk("overflow idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("overflow pulse width", 32'(ovf), 32'd0);
    count_done(30, "overflow");
    check_all("after overflow");

    @(negedge clk);
    clr = 1'b1; start = 1'b1; k_drv = fbits(0.5);
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    model_clear();
    chk("clear wins order", 32'(order), 32'd0);
    chk("clear wins idle", 32'(busy), 32'd0);
    count_done(20, "clear+start");

    repeat (6) begin
      do_step(kset[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), "rand");
      check_all("rand");
    end

    @(negedge clk);
    k_drv = fbits(0.25);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("drain busy", 32'(busy), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort idle", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    count_done(25, "abort");
    check_all("after abort");
    do_step(kset[$urandom_range(0, 5)], 1'b0, "post-abort");
    check_all("post-abort");

    @(negedge clk);
    ridx = 5'd1;
    k_drv = fbits(0.5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("pre-reset busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid-issue reset oCoef", coef, 32'd0);
    chk("mid-issue reset oOrder", 32'(order), 32'd0);
    chk("mid-issue reset oBusy", 32'(busy), 32'd0);
    chk("mid-issue reset oDone", 32'(done), 32'd0);
    chk("mid-issue reset oOverflow", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    count_done(25, "after reset");
    do_step(0.5, 1'b0, "post-reset");
    read_coef(1, v);
    chk("post-reset a1", v, 32'h3F000000);
    chk("post-reset order", 32'(order), 32'd1);
    check_all("post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
